// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronizes and de-glitches the PS/2 pins, deserializes
// 11-bit device-to-host frames and folds E0/F0 prefixes into flags on each key event.
module ps2_keyboard_rx #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 25000
) (
  input  logic       CLOCK,
  input  logic       RESET_N,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] CODE,
  output logic       EXTENDED,
  output logic       RELEASE,
  output logic       READY,
  output logic       ERROR
);

  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  logic          clk_meta, clk_sync, dat_meta, dat_sync;
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic          fall;

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          parity_bit;
  logic [TW-1:0] to_cnt;
  logic          ext_flag, rel_flag;

  // Two-flop synchronizers; idle PS/2 lines are high, so reset to 1.
  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, exactly as the hardware does.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      clk_meta <= 1'b1;
      clk_sync <= 1'b1;
      dat_meta <= 1'b1;
      dat_sync <= 1'b1;
    end else begin
      clk_meta <= PS2_CLK;
      clk_sync <= clk_meta;
      dat_meta <= PS2_DAT;
      dat_sync <= dat_meta;
    end
  end

  // Filtered clock follows the synced level only after FILTER consecutive
  // differing samples; fall is a one-cycle pulse as the filtered level drops.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_sync == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_MAX) begin
        clk_filt <= clk_sync;
        filt_cnt <= '0;
        fall     <= ~clk_sync;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  // Frame FSM with registered outputs; READY/ERROR default low each cycle.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      parity_bit <= 1'b0;
      to_cnt     <= '0;
      ext_flag   <= 1'b0;
      rel_flag   <= 1'b0;
      CODE       <= '0;
      EXTENDED   <= 1'b0;
      RELEASE    <= 1'b0;
      READY      <= 1'b0;
      ERROR      <= 1'b0;
    end else begin
      READY <= 1'b0;
      ERROR <= 1'b0;
      if (state == ST_IDLE) begin
        to_cnt <= '0;
        if (fall && !dat_sync) begin
          state   <= ST_DATA;
          bit_cnt <= '0;
        end
      end else if (fall) begin
        // An edge always takes priority over a timeout in the same cycle.
        to_cnt <= '0;
        case (state)
          ST_DATA: begin
            shreg   <= {dat_sync, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            parity_bit <= dat_sync;
            state      <= ST_STOP;
          end
          default: begin
            state <= ST_IDLE;
            if (dat_sync && (^{shreg, parity_bit})) begin
              case (shreg)
                8'hE0:   ext_flag <= 1'b1;
                8'hF0:   rel_flag <= 1'b1;
                default: begin
                  CODE     <= shreg;
                  EXTENDED <= ext_flag;
                  RELEASE  <= rel_flag;
                  READY    <= 1'b1;
                  ext_flag <= 1'b0;
                  rel_flag <= 1'b0;
                end
              endcase
            end else begin
              ERROR    <= 1'b1;
              ext_flag <= 1'b0;
              rel_flag <= 1'b0;
            end
          end
        endcase
      end else if (to_cnt == TO_MAX) begin
        state    <= ST_IDLE;
        to_cnt   <= '0;
        ERROR    <= 1'b1;
        ext_flag <= 1'b0;
        rel_flag <= 1'b0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx: a frame-level event model predicts every
// READY/ERROR strobe and the held CODE/EXTENDED/RELEASE values, checked each cycle.
`timescale 1ns/1ps
module tb_ps2_keyboard_rx;

  localparam int FILTER  = 8;
  localparam int TIMEOUT = 2000;
  localparam int HALF    = 25;  // PS/2 half-period in system cycles (scaled-up rate keeps runs short)

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] code;
  logic       extended, release_o, ready, error;

  ps2_keyboard_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .CLOCK    (clk),
    .RESET_N  (rst_n),
    .PS2_CLK  (ps2_clk),
    .PS2_DAT  (ps2_dat),
    .CODE     (code),
    .EXTENDED (extended),
    .RELEASE  (release_o),
    .READY    (ready),
    .ERROR    (error)
  );

  always #20 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] code;
    bit         ext;
    bit         rel;
  } event_t;

  event_t     exp_q[$];
  event_t     cur;
  bit         m_ext, m_rel;
  logic [7:0] last_code;
  bit         last_ext, last_rel;
  int         checks = 0;
  int         errors = 0;
  int         ready_seen = 0;
  int         error_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    exp_q.delete();
    m_ext     = 1'b0;
    m_rel     = 1'b0;
    last_code = 8'h00;
    last_ext  = 1'b0;
    last_rel  = 1'b0;
  endfunction

  function automatic void push_error();
    event_t e;
    e.is_err = 1'b1;
    e.code   = 8'h00;
    e.ext    = 1'b0;
    e.rel    = 1'b0;
    exp_q.push_back(e);
    m_ext = 1'b0;
    m_rel = 1'b0;
  endfunction

  // What a complete frame must produce, from the protocol rules alone.
  function automatic void model_frame(input logic [7:0] b, input logic p, input logic s);
    event_t e;
    if (!(s && ((^b) ^ p))) begin
      push_error();
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_rel = 1'b1;
    end else begin
      e.is_err = 1'b0;
      e.code   = b;
      e.ext    = m_ext;
      e.rel    = m_rel;
      exp_q.push_back(e);
      m_ext = 1'b0;
      m_rel = 1'b0;
    end
  endfunction

  // Compare process: strobes are matched against the event queue in order,
  // held outputs against the last READY event, on every falling clock edge.
  always @(negedge clk) begin
    check("ready_and_error", {31'd0, ready & error}, 32'd0);
    if (ready) begin
      ready_seen++;
      check("ready_expected", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        check("ready_kind", {31'd0, cur.is_err}, 32'd0);
        check("ready_code", {24'd0, code}, {24'd0, cur.code});
        check("ready_ext", {31'd0, extended}, {31'd0, cur.ext});
        check("ready_rel", {31'd0, release_o}, {31'd0, cur.rel});
        last_code = cur.code;
        last_ext  = cur.ext;
        last_rel  = cur.rel;
      end
    end
    if (error) begin
      error_seen++;
      check("error_expected", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        check("error_kind", {31'd0, cur.is_err}, 32'd1);
      end
    end
    check("code_hold", {24'd0, code}, {24'd0, last_code});
    check("ext_hold", {31'd0, extended}, {31'd0, last_ext});
    check("rel_hold", {31'd0, release_o}, {31'd0, last_rel});
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One PS/2 bit: data changes mid-high, then the clock is low for a half-period.
  task automatic ps2_bit(input logic b, input bit glitch);
    if (glitch) begin
      wait_cycles(2);
      ps2_clk = 1'b0;
      wait_cycles(FILTER - 1);
      ps2_clk = 1'b1;
    end
    wait_cycles(12);
    ps2_dat = b;
    wait_cycles(HALF - 12);
    ps2_clk = 1'b0;
    wait_cycles(HALF);
    ps2_clk = 1'b1;
  endtask

  // Sends the first nbits of a frame (all 11 for a complete one).
  task automatic send_bits(input logic [7:0] b, input logic bad_par, input logic stop,
                           input int nbits, input int glitch_bit);
    logic [10:0] bits;
    bits = {stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(bits[i], i == glitch_bit);
    wait_cycles(12);
    ps2_dat = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop,
                            input int glitch_bit);
    model_frame(b, (~^b) ^ bad_par, stop);
    send_bits(b, bad_par, stop, 11, glitch_bit);
    wait_cycles(40);
  endtask

  task automatic test_end(input string name, input int nready, input int nerr,
                          input logic [7:0] c, input logic e, input logic r);
    check({name, "_ready_count"}, ready_seen, nready);
    check({name, "_error_count"}, error_seen, nerr);
    check({name, "_pending"}, exp_q.size(), 32'd0);
    check({name, "_code"}, {24'd0, code}, {24'd0, c});
    check({name, "_ext"}, {31'd0, extended}, {31'd0, e});
    check({name, "_rel"}, {31'd0, release_o}, {31'd0, r});
    ready_seen = 0;
    error_seen = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    wait_cycles(5);
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_error", {31'd0, error}, 32'd0);
    rst_n = 1'b1;
    wait_cycles(20);
    test_end("reset", 0, 0, 8'h00, 1'b0, 1'b0);

    // 1: plain make code
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    test_end("t1", 1, 0, 8'h1C, 1'b0, 1'b0);

    // 2: break code
    send_frame(8'hF0, 1'b0, 1'b1, -1);
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    test_end("t2", 1, 0, 8'h1C, 1'b0, 1'b1);

    // 3: extended break, then flags cleared
    send_frame(8'hE0, 1'b0, 1'b1, -1);
    send_frame(8'hF0, 1'b0, 1'b1, -1);
    send_frame(8'h75, 1'b0, 1'b1, -1);
    test_end("t3a", 1, 0, 8'h75, 1'b1, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    test_end("t3b", 1, 0, 8'h1C, 1'b0, 1'b0);

    // 4: parity error, stop-bit error, then recovery
    send_frame(8'h1C, 1'b1, 1'b1, -1);
    test_end("t4a", 0, 1, 8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0, -1);
    test_end("t4b", 0, 1, 8'h1C, 1'b0, 1'b0);
    send_frame(8'h29, 1'b0, 1'b1, -1);
    test_end("t4c", 1, 0, 8'h29, 1'b0, 1'b0);

    // 5: truncated frame times out; a pending F0 must not leak past the error
    send_frame(8'hF0, 1'b0, 1'b1, -1);
    push_error();
    send_bits(8'h5A, 1'b0, 1'b1, 5, -1);
    wait_cycles(TIMEOUT + 10);
    test_end("t5a", 0, 1, 8'h29, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    test_end("t5b", 1, 0, 8'h1C, 1'b0, 1'b0);

    // 6: short clock glitch inside a frame adds no bit
    send_frame(8'hE0, 1'b0, 1'b1, -1);
    send_frame(8'h6B, 1'b0, 1'b1, 4);
    test_end("t6a", 1, 0, 8'h6B, 1'b1, 1'b0);

    // 6: reset mid-frame, then normal decode
    send_bits(8'h33, 1'b0, 1'b1, 4, -1);
    rst_n = 1'b0;
    model_reset();
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    wait_cycles(5);
    rst_n = 1'b1;
    wait_cycles(30);
    test_end("t6b", 0, 0, 8'h00, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    test_end("t6c", 1, 0, 8'h1C, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
